// File: rtl/net_frame_feeder.sv
// Frame buffer and burst feeder in front of the digit-recognition network.
// Optional watchdog on the result wait: define NET_TIMEOUT_EN.
module net_frame_feeder #(
    parameter int dataWidth     = 16,
    parameter int pixelWidth    = 8,
    parameter int fracBits      = 8,
    parameter int numPixels     = 784,
    parameter int outWidth      = 4,
    parameter int timeoutCycles = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [pixelWidth-1:0] pix_data,
    input  logic                  pix_last,
    output logic                  net_valid,
    output logic [dataWidth-1:0]  net_data,
    input  logic                  net_res_valid,
    input  logic [outWidth-1:0]   net_res_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [outWidth-1:0]   res_data,
    output logic                  res_timeout,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int ShiftAmt = fracBits - pixelWidth;
    localparam int AW = (numPixels > 1) ? $clog2(numPixels) : 1;
    localparam int CW = $clog2(numPixels + 1);

    typedef enum logic [2:0] {
        LOAD,
        DROP,
        STREAM,
        WAIT,
        RESULT
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         wr_ptr_nxt;
    logic [CW-1:0]         rd_cnt;
    logic [AW-1:0]         rd_idx;
    logic                  rd_en;
    logic                  xfer;
    logic                  wr_last;
    logic                  err_nxt;
    logic                  res_load;
    logic [outWidth-1:0]   res_in;
    logic [pixelWidth-1:0] mem [numPixels];

`ifdef NET_TIMEOUT_EN
    localparam int TW = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
    logic [TW-1:0] to_cnt;
    logic          to_in;
    logic          res_to_q;
`endif

    assign pix_ready = (state == LOAD) || (state == DROP);
    assign res_valid = (state == RESULT);
    assign busy      = (state != LOAD);
    assign xfer      = pix_valid && pix_ready;
    assign wr_last   = (wr_ptr == AW'(numPixels - 1));
    assign rd_en     = (state == STREAM) && (rd_cnt != CW'(numPixels));
    assign rd_idx    = rd_cnt[AW-1:0];

    // Next-state, write-pointer and result-capture decisions.
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        err_nxt    = 1'b0;
        res_load   = 1'b0;
        res_in     = net_res_data;
`ifdef NET_TIMEOUT_EN
        to_in      = 1'b0;
`endif
        unique case (state)
            LOAD: begin
                if (xfer) begin
                    if (wr_last) begin
                        wr_ptr_nxt = '0;
                        if (pix_last) begin
                            state_nxt = STREAM;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = DROP;
                        end
                    end else if (pix_last) begin
                        err_nxt    = 1'b1;
                        wr_ptr_nxt = '0;
                    end else begin
                        wr_ptr_nxt = wr_ptr + AW'(1);
                    end
                end
            end
            DROP: begin
                if (xfer && pix_last) state_nxt = LOAD;
            end
            STREAM: begin
                if (rd_cnt == CW'(numPixels)) state_nxt = WAIT;
            end
            WAIT: begin
                if (net_res_valid) begin
                    res_load  = 1'b1;
                    state_nxt = RESULT;
                end
`ifdef NET_TIMEOUT_EN
                else if (to_cnt == TW'(timeoutCycles - 1)) begin
                    res_load  = 1'b1;
                    res_in    = '1;
                    to_in     = 1'b1;
                    state_nxt = RESULT;
                end
`endif
            end
            RESULT: begin
                if (res_ready) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Control state, burst read path and held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            wr_ptr    <= '0;
            rd_cnt    <= '0;
            net_valid <= 1'b0;
            net_data  <= '0;
            res_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            frame_err <= err_nxt;
            net_valid <= rd_en;
            if (rd_en) begin
                rd_cnt   <= rd_cnt + CW'(1);
                net_data <= dataWidth'(mem[rd_idx]) << ShiftAmt;
            end else if (state != STREAM) begin
                rd_cnt <= '0;
            end
            if (res_load) res_data <= res_in;
        end
    end

    // Frame buffer write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (rst_n && (state == LOAD) && xfer) mem[wr_ptr] <= pix_data;
    end

`ifdef NET_TIMEOUT_EN
    // Watchdog counts cycles spent in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt   <= '0;
            res_to_q <= 1'b0;
        end else begin
            if (state != WAIT) to_cnt <= '0;
            else               to_cnt <= to_cnt + TW'(1);
            if (res_load) res_to_q <= to_in;
        end
    end

    assign res_timeout = res_to_q;
`else
    assign res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_net_frame_feeder.sv
// Directed bench for net_frame_feeder with a timeline-based reference model.
// Build with NET_TIMEOUT_EN to exercise the watchdog path.
module tb_net_frame_feeder;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int PW = 8;
    localparam int FB = 8;
    localparam int OW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [PW-1:0] pix_data = '0;
    logic          pix_last = 1'b0;
    logic          net_valid;
    logic [DW-1:0] net_data;
    logic          net_res_valid = 1'b0;
    logic [OW-1:0] net_res_data = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [OW-1:0] res_data;
    logic          res_timeout;
    logic          frame_err;
    logic          busy;

    net_frame_feeder #(
        .dataWidth(DW), .pixelWidth(PW), .fracBits(FB),
        .numPixels(N), .outWidth(OW), .timeoutCycles(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last),
        .net_valid(net_valid), .net_data(net_data),
        .net_res_valid(net_res_valid), .net_res_data(net_res_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_timeout(res_timeout),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    // Reference model: frame completion at edge t gives valid cycles t+1..t+N,
    // waiting from t+N+1 onward.
    bit          m_on = 0;
    bit          m_busy, m_drop, m_res, m_ferr, m_rto;
    int          m_cnt, m_tdone;
    logic [7:0]  m_buf [N];
    logic [7:0]  m_frm [N];
    logic [3:0]  m_rdata;

    function automatic logic [DW-1:0] conv(input logic [7:0] p);
        return DW'(int'(p) * (1 << (FB - PW)));
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_on = 1; m_busy = 0; m_drop = 0; m_res = 0;
            m_cnt = 0; m_ferr = 0; m_rdata = 0; m_rto = 0;
        end else if (m_on) begin
            m_ferr = 0;
            if (m_res) begin
                if (res_ready) m_res = 0;
            end else if (m_busy) begin
                if (cyc - 1 >= m_tdone + N + 1) begin
                    if (net_res_valid) begin
                        m_busy = 0; m_res = 1;
                        m_rdata = net_res_data; m_rto = 0;
                    end
`ifdef NET_TIMEOUT_EN
                    else if ((cyc - 1) - (m_tdone + N + 1) == TO - 1) begin
                        m_busy = 0; m_res = 1;
                        m_rdata = 4'hF; m_rto = 1;
                    end
`endif
                end
            end else if (pix_valid) begin
                if (m_drop) begin
                    if (pix_last) m_drop = 0;
                end else begin
                    m_buf[m_cnt] = pix_data;
                    if (m_cnt == N - 1) begin
                        m_cnt = 0;
                        if (pix_last) begin
                            m_busy = 1; m_tdone = cyc; m_frm = m_buf;
                        end else begin
                            m_ferr = 1; m_drop = 1;
                        end
                    end else if (pix_last) begin
                        m_ferr = 1; m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    end

    logic [DW-1:0] cap [$];
    int            first_nv = -1;
    int            ferr_cnt = 0;

    // Per-cycle compare against the model, plus capture monitors.
    always @(negedge clk) begin
        if (m_on) begin
            bit exp_nv;
            exp_nv = m_busy && (cyc >= m_tdone + 1) && (cyc <= m_tdone + N);
            chk("pix_ready", pix_ready, !m_busy && !m_res);
            chk("net_valid", net_valid, exp_nv);
            if (exp_nv) chk("net_data", net_data, conv(m_frm[cyc - m_tdone - 1]));
            chk("res_valid", res_valid, m_res);
            if (m_res) begin
                chk("res_data", res_data, m_rdata);
                chk("res_timeout", res_timeout, m_rto);
            end
            chk("frame_err", frame_err, m_ferr);
            if (!m_drop) chk("busy", busy, m_busy || m_res);
        end
        if (net_valid === 1'b1) begin
            if (cap.size() == 0) first_nv = cyc;
            cap.push_back(net_data);
        end
        if (frame_err === 1'b1) ferr_cnt++;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int px_cyc;

    task automatic send_pix(input logic [7:0] d, input bit l);
        int w = 0;
        while (!pix_ready && w < 50) begin
            step(); w++;
        end
        if (!pix_ready) chk("pix_ready_wait", 0, 1);
        pix_valid = 1; pix_data = d; pix_last = l; px_cyc = cyc;
        step();
        pix_valid = 0; pix_last = 0;
    endtask

    task automatic send_frame(input logic [7:0] a, b, c, d);
        send_pix(a, 0); send_pix(b, 0); send_pix(c, 0); send_pix(d, 1);
    endtask

    task automatic wait_nv(input int target);
        int w = 0;
        while (cap.size() < target && w < 100) begin
            step(); w++;
        end
        if (cap.size() < target) chk("net_valid_wait", cap.size(), target);
    endtask

    task automatic wait_res(output logic [3:0] d, output logic t);
        int w = 0;
        while (!res_valid && w < 100) begin
            step(); w++;
        end
        if (!res_valid) chk("res_valid_wait", 0, 1);
        d = res_data; t = res_timeout;
    endtask

    task automatic pulse_res(input logic [3:0] r);
        net_res_valid = 1; net_res_data = r;
        step();
        net_res_valid = 0;
    endtask

    task automatic finish_frame(input logic [3:0] r);
        logic [3:0] d;
        logic       t;
        wait_nv(N);
        step(2);
        pulse_res(r);
        wait_res(d, t);
        step();
    endtask

    initial begin
        logic [DW-1:0] lit [N];
        logic [3:0]    rd;
        logic          rt;
        int            cnt, w;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);

        pulse_res(4'd9);
        res_ready = 1;
        cap.delete();
        send_frame(8'h00, 8'h80, 8'hFF, 8'h01);
        wait_nv(N);
        chk("latency", first_nv - px_cyc, 2);
        lit = '{16'h0000, 16'h0080, 16'h00FF, 16'h0001};
        for (int i = 0; i < N; i++) chk("normal_data", cap[i], lit[i]);
        step(2);
        pulse_res(4'd7);
        wait_res(rd, rt);
        chk("normal_res", rd, 4'd7);
        chk("normal_to", rt, 0);
        step();

        cap.delete(); ferr_cnt = 0;
        send_pix(8'h05, 0); send_pix(8'h06, 1);
        step(3);
        chk("early_ferr", ferr_cnt, 1);
        chk("early_nonv", cap.size(), 0);
        send_frame(8'h10, 8'h20, 8'h30, 8'h40);
        finish_frame(4'd2);
        chk("early_next", cap[0], 16'h0010);

        cap.delete(); ferr_cnt = 0;
        for (int i = 0; i < 6; i++) send_pix(8'(8'hA0 + i), i == 5);
        step(3);
        chk("miss_ferr", ferr_cnt, 1);
        chk("miss_nonv", cap.size(), 0);
        send_frame(8'h21, 8'h22, 8'h23, 8'h24);
        finish_frame(4'd1);
        chk("miss_next", cap[3], 16'h0024);

        cap.delete();
        res_ready = 0;
        send_frame(8'h31, 8'h32, 8'h33, 8'h34);
        pix_valid = 1; pix_data = 8'hAA;
        wait_nv(N);
        step(2);
        pulse_res(4'd3);
        step(12);
        chk("bp_hold", res_data, 4'd3);
        pix_valid = 0; res_ready = 1;
        step(2);
        cap.delete();
        send_frame(8'h41, 8'h42, 8'h43, 8'h44);
        finish_frame(4'd4);
        chk("bp_next", cap[1], 16'h0042);

        cap.delete();
        send_frame(8'h51, 8'h52, 8'h53, 8'h54);
        cnt = 0; w = 0;
        while (cnt < 2 && w < 50) begin
            if (net_valid) cnt++;
            if (cnt < 2) begin
                step(); w++;
            end
        end
        if (cnt < 2) chk("rst_mid_wait", cnt, 2);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("rst_mid_nv", net_valid, 0);
        chk("rst_mid_ready", pix_ready, 1);
        cap.delete();
        send_frame(8'h11, 8'h22, 8'h33, 8'h44);
        finish_frame(4'd6);
        chk("rst_mid_first", cap[0], 16'h0011);

        cap.delete();
        send_frame(8'h61, 8'h62, 8'h63, 8'h64);
        wait_nv(N);
`ifdef NET_TIMEOUT_EN
        wait_res(rd, rt);
        chk("to_data", rd, 4'hF);
        chk("to_flag", rt, 1);
        step();
`else
        step(30);
        chk("no_to_wait", res_valid, 0);
        pulse_res(4'd5);
        wait_res(rd, rt);
        chk("no_to_flag", rt, 0);
        step();
`endif
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
